// File: rtl/count_scheduler_pkg.sv
// rtl/count_scheduler_pkg.sv - shared types, defaults and round-robin pick helper for count_scheduler
package count_sched_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Returns {found, index} of the first set bit at or after ptr, wrapping modulo n (n <= 8).
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                           input logic [3:0] n);
        logic       found;
        logic [2:0] idx;
        int         k;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            k = (int'(ptr) + i) % int'(n);
            if (i < int'(n) && !found && req[k[2:0]]) begin
                found = 1'b1;
                idx   = k[2:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/count_scheduler_if.sv
// rtl/count_scheduler_if.sv - requester-side bundle of the count_scheduler
interface count_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 5
);
    logic [NUM_REQ-1:0]         i_req;
    logic [NUM_REQ*CNT_W-1:0]   i_len;
    logic                       i_pause;
    logic [NUM_REQ-1:0]         o_grant;
    logic [$clog2(NUM_REQ)-1:0] o_owner;
    logic [NUM_REQ-1:0]         o_done;
    logic                       o_busy;
    logic [CNT_W-1:0]           o_count;

    modport master (
        output i_req, i_len, i_pause,
        input  o_grant, o_owner, o_done, o_busy, o_count
    );

    modport slave (
        input  i_req, i_len, i_pause,
        output o_grant, o_owner, o_done, o_busy, o_count
    );
endinterface

// File: rtl/count_scheduler_interval_counter.sv
// rtl/count_scheduler_interval_counter.sv - loadable up-counter; load takes priority over enable
module interval_counter #(
    parameter int CNT_W = 5
) (
    input  logic             i_clock,
    input  logic             i_rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] data,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= data;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/count_scheduler.sv
// rtl/count_scheduler.sv - round-robin arbiter lending one interval counter to NUM_REQ requesters
module count_scheduler
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic             i_clock,
    input logic             i_rst_n,
    count_scheduler_if.slave bus
);

    localparam int OWN_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("count_scheduler supports NUM_REQ of 2..8 only");
    end

    state_t             state;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   count;
    logic [OWN_W-1:0]   owner_q;
    logic [OWN_W-1:0]   rr_ptr;
    logic [OWN_W-1:0]   next_ptr;
    logic [OWN_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [CNT_W-1:0]   pick_len;
    logic [7:0]         req_pad;
    logic [3:0]         pick;
    logic               pick_vld;
    logic               busy_q;
    logic               owner_req;
    logic               cnt_load;
    logic               cnt_en;

    always_comb begin
        req_pad                = '0;
        req_pad[NUM_REQ-1:0]   = bus.i_req;
    end

    assign pick     = rr_pick(req_pad, 3'(rr_ptr), 4'(NUM_REQ));
    assign pick_vld = pick[3];
    assign pick_idx = OWN_W'(pick[2:0]);

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
        pick_len              = bus.i_len[pick_idx*CNT_W +: CNT_W];
    end

    assign next_ptr  = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_req = bus.i_req[owner_q];
    assign cnt_load  = (state == ST_LOAD);
    // The compare against len_q stops the counter at the target, so it can never wrap.
    assign cnt_en    = (state == ST_RUN) && (count != len_q) && !bus.i_pause;

    interval_counter #(.CNT_W(CNT_W)) u_counter (
        .i_clock (i_clock),
        .i_rst_n (i_rst_n),
        .load    (cnt_load),
        .enable  (cnt_en),
        .data    ({CNT_W{1'b0}}),
        .count   (count)
    );

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            owner_q <= '0;
            rr_ptr  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state   <= ST_LOAD;
                        owner_q <= pick_idx;
                        len_q   <= pick_len;
                        grant_q <= pick_onehot;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!owner_req) begin
                        state   <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        rr_ptr  <= next_ptr;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A dropped request abandons the interval without a completion pulse.
                    if (!owner_req) begin
                        state   <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        rr_ptr  <= next_ptr;
                    end else if (count == len_q) begin
                        state  <= ST_DONE;
                        done_q <= grant_q;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    done_q  <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    rr_ptr  <= next_ptr;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_grant = grant_q;
    assign bus.o_owner = owner_q;
    assign bus.o_done  = done_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_count = count;

endmodule

// File: tb/tb_count_scheduler.sv
// tb/tb_count_scheduler.sv - scoreboard bench for count_scheduler against a timeline model
module tb_count_scheduler;

    localparam int N    = 4;
    localparam int W    = 5;
    localparam int MAXC = 2048;

    typedef struct {
        int owner;
        int len;
        int t_done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    count_scheduler_if #(.NUM_REQ(N), .CNT_W(W)) bus ();

    count_scheduler #(.NUM_REQ(N), .CNT_W(W)) dut (
        .i_clock (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t         exp_q[$];
    logic [N-1:0] exp_grant [MAXC];
    int           exp_own   [MAXC];
    int           exp_cnt   [MAXC];
    int           len_owner [MAXC];
    int           len_arr   [MAXC];
    logic [N-1:0] req_arr   [MAXC];
    bit           pause_arr [MAXC];
    int           jobs[N][$];
    int           ptr_m;
    int           t_end;
    int           base;
    bit           sb_on = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    // Timeline model: each interval occupies sample cycle t, LOAD at t+1, RUN from t+2 while
    // counting unpaused cycles up to len, then DONE one cycle after reaching len.
    task automatic build_model();
        int jidx[N];
        int last_done[N];
        int t, c, cnt, len, sel, done, kk;
        for (int i = 0; i < MAXC; i++) begin
            exp_grant[i] = '0;
            exp_own[i]   = 0;
            exp_cnt[i]   = -1;
            len_owner[i] = -1;
            len_arr[i]   = 0;
            req_arr[i]   = '0;
        end
        for (int k = 0; k < N; k++) begin
            jidx[k]      = 0;
            last_done[k] = -1;
        end
        t = 0;
        forever begin
            sel = -1;
            for (int i = 0; i < N; i++) begin
                kk = (ptr_m + i) % N;
                if (sel < 0 && jidx[kk] < jobs[kk].size()) sel = kk;
            end
            if (sel < 0) break;
            len = jobs[sel][jidx[sel]];
            len_owner[t] = sel;
            len_arr[t]   = len;
            c   = t + 2;
            cnt = 0;
            while (c < MAXC - 8) begin
                exp_cnt[c] = cnt;
                if (cnt == len) break;
                if (!pause_arr[c]) cnt++;
                c++;
            end
            done = c + 1;
            exp_cnt[done] = len;
            for (int cc = t + 1; cc <= done; cc++) begin
                exp_grant[cc] = N'(1) << sel;
                exp_own[cc]   = sel;
            end
            exp_q.push_back('{owner: sel, len: len, t_done: done});
            last_done[sel] = done;
            jidx[sel]++;
            ptr_m = (sel + 1) % N;
            t = done + 1;
        end
        t_end = t;
        for (int cc = 0; cc <= t_end + 3; cc++)
            for (int k = 0; k < N; k++)
                req_arr[cc][k] = (cc <= last_done[k]);
    endtask

    // Lengths are only meaningful on sample cycles; everything else is scrambled so a
    // design that re-reads i_len after capture is caught.
    task automatic drive(input int c);
        bus.i_req   = req_arr[c];
        bus.i_pause = pause_arr[c];
        for (int k = 0; k < N; k++) bus.i_len[k*W +: W] = W'($urandom);
        if (len_owner[c] >= 0) bus.i_len[len_owner[c]*W +: W] = W'(len_arr[c]);
    endtask

    task automatic run_schedule();
        build_model();
        @(posedge clk);
        #1;
        base  = cyc;
        sb_on = 1'b1;
        for (int c = 0; c <= t_end + 3; c++) begin
            drive(c);
            @(posedge clk);
            #1;
        end
        sb_on = 1'b0;
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic clear_cfg();
        for (int k = 0; k < N; k++) jobs[k].delete();
        for (int c = 0; c < MAXC; c++) pause_arr[c] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        bus.i_req   = '0;
        bus.i_pause = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    always @(negedge clk) begin : monitor
        int rel;
        logic [N-1:0] exp_done;
        if (sb_on) begin
            rel = cyc - base;
            check("grant", int'(bus.o_grant), int'(exp_grant[rel]));
            check("busy", int'(bus.o_busy), int'(exp_grant[rel] != '0));
            if (exp_grant[rel] != '0) check("owner", int'(bus.o_owner), exp_own[rel]);
            if (exp_cnt[rel] >= 0) check("count", int'(bus.o_count), exp_cnt[rel]);
            exp_done = '0;
            if (exp_q.size() > 0 && exp_q[0].t_done == rel) begin
                exp_done = N'(1) << exp_q[0].owner;
                void'(exp_q.pop_front());
            end
            check("done", int'(bus.o_done), int'(exp_done));
        end
    end

    initial begin
        int  found;
        bit  seen2;
        int  r, n, total;
        bus.i_req   = '0;
        bus.i_len   = '0;
        bus.i_pause = 1'b0;
        ptr_m       = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", int'(bus.o_grant), 0);
        check("rst_done",  int'(bus.o_done),  0);
        check("rst_busy",  int'(bus.o_busy),  0);
        check("rst_count", int'(bus.o_count), 0);
        check("rst_owner", int'(bus.o_owner), 0);
        rst_n = 1'b1;

        // single requester, len 3
        clear_cfg();
        jobs[0].push_back(3);
        run_schedule();

        // contention, all len 1, requester 0 comes back for a second turn
        do_reset();
        clear_cfg();
        jobs[0].push_back(1);
        jobs[0].push_back(1);
        for (int k = 1; k < N; k++) jobs[k].push_back(1);
        run_schedule();

        // boundary lengths 0 and 2^W-1
        do_reset();
        clear_cfg();
        jobs[1].push_back(0);
        jobs[2].push_back(31);
        run_schedule();

        // pause for 3 RUN cycles, plus pause in LOAD and DONE which must be ignored
        do_reset();
        clear_cfg();
        jobs[0].push_back(4);
        pause_arr[1]  = 1'b1;
        pause_arr[3]  = 1'b1;
        pause_arr[4]  = 1'b1;
        pause_arr[5]  = 1'b1;
        pause_arr[10] = 1'b1;
        run_schedule();

        // abort requester 2 at count 2 of len 10
        do_reset();
        bus.i_len = '0;
        bus.i_len[2*W +: W] = W'(10);
        bus.i_len[3*W +: W] = W'(2);
        bus.i_req = 4'b1100;
        found = 0;
        seen2 = 1'b0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (bus.o_done[2]) seen2 = 1'b1;
            if (bus.o_grant == 4'b0100 && bus.o_count == W'(2)) found = 1;
        end
        check("abort_reach_count2", found, 1);
        bus.i_req[2] = 1'b0;
        @(negedge clk);
        if (bus.o_done[2]) seen2 = 1'b1;
        check("abort_idle_grant", int'(bus.o_grant), 0);
        check("abort_idle_busy", int'(bus.o_busy), 0);
        bus.i_req[2] = 1'b1;
        @(negedge clk);
        if (bus.o_done[2]) seen2 = 1'b1;
        check("abort_next_grant", int'(bus.o_grant), 4'b1000);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (bus.o_done[2]) seen2 = 1'b1;
            if (bus.o_done != '0) begin
                found = 1;
                check("abort_next_done", int'(bus.o_done), 4'b1000);
                bus.i_req = '0;
            end
        end
        check("abort_next_done_seen", found, 1);
        check("abort_no_done2", int'(seen2), 0);

        // reset in the middle of RUN
        do_reset();
        bus.i_len = '0;
        bus.i_len[0 +: W] = W'(10);
        bus.i_req = 4'b0001;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (bus.o_grant == 4'b0001 && bus.o_count == W'(5)) found = 1;
        end
        check("midrun_reach_count5", found, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_grant", int'(bus.o_grant), 0);
        check("midrun_rst_done",  int'(bus.o_done),  0);
        check("midrun_rst_busy",  int'(bus.o_busy),  0);
        check("midrun_rst_count", int'(bus.o_count), 0);
        bus.i_req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrun_first_grant", int'(bus.o_grant), 4'b0010);
        check("midrun_first_owner", int'(bus.o_owner), 1);
        do_reset();

        // randomized rounds; the round-robin pointer carries over between rounds
        for (int round = 0; round < 4; round++) begin
            clear_cfg();
            total = 0;
            for (int k = 0; k < N; k++) begin
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) begin
                    r = $urandom_range(0, 3);
                    jobs[k].push_back(r == 0 ? 0 : (r == 1 ? 31 : int'($urandom_range(0, 31))));
                    total++;
                end
            end
            if (total == 0) jobs[0].push_back(5);
            for (int c = 0; c < MAXC; c++) pause_arr[c] = ($urandom_range(0, 3) == 0);
            run_schedule();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_scheduler.md
COUNT_SCHEDULER -- requirements
Module: count_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requesters; the design SHALL support only 2..8.
REQ-002 Parameter CNT_W, default 5, meaning counter and length width.
REQ-003 Port i_clock  input  1  system clock; all state changes on rising edge.
REQ-004 Port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port i_req  input  NUM_REQ  per-requester interval request; held high until that requester's o_done or until it chooses to abort.
REQ-006 Port i_len  input  NUM_REQ*CNT_W  packed interval lengths; slice k = i_len[k*CNT_W +: CNT_W].
REQ-007 Port i_pause  input  1  when high, count held during RUN.
REQ-008 Port o_grant  output  NUM_REQ  one-hot owner of the shared counter; all-zero when idle.
REQ-009 Port o_owner  output  $clog2(NUM_REQ)  index of current or last owner.
REQ-010 Port o_done  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-011 Port o_busy  output  1  high in any state other than IDLE.
REQ-012 Port o_count  output  CNT_W  current shared counter value.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, RUN, DONE.
REQ-014 IDLE: if any i_req bit is high, select the first requester at or after rr_ptr (round-robin, wrapping), capture its i_len slice into len_q, set owner, go to LOAD; else stay.
REQ-015 LOAD: counter loaded with 0; o_grant[owner] high; go to RUN next cycle.
REQ-016 RUN: if count == len_q, go to DONE; else if i_pause low, count increments by 1; else count holds.
REQ-017 DONE: o_done[owner] high for exactly this cycle, rr_ptr <= owner+1 mod NUM_REQ, go to IDLE.
REQ-018 o_grant[owner] SHALL be high in LOAD, RUN and DONE and zero in IDLE.
REQ-019 Latency with i_pause low: req sampled in IDLE at cycle t, o_done at cycle t+len+3; next grant no earlier than t+len+5.
REQ-020 len_q = 0 SHALL go LOAD -> RUN -> DONE with o_count staying 0.
REQ-021 len_q = 2^CNT_W-1 SHALL complete without counter wrap-around; count never exceeds len_q.
REQ-022 i_len changes after capture SHALL not affect the running interval.
REQ-023 Abort: i_req[owner] low during LOAD or RUN SHALL return to IDLE next cycle, with no o_done and rr_ptr <= owner+1.
REQ-024 i_pause high during LOAD or DONE SHALL have no effect.
REQ-025 Simultaneous requests SHALL never produce more than one o_grant bit; a requester arriving during RUN waits for IDLE.

Reset
REQ-026 While i_rst_n is low: state IDLE, o_grant 0, o_done 0, o_busy 0, o_count 0, o_owner 0, rr_ptr 0, len_q 0.
REQ-027 Reset asserted mid-operation SHALL clear all state immediately without issuing o_done; the first grant after release goes to the lowest-index active requester.

Structure
REQ-028 Package count_sched_pkg SHALL hold NUM_REQ and CNT_W defaults and the state enum typedef.
REQ-029 The counter SHALL be a sub-module interval_counter (inputs clock, reset, load, enable, CNT_W data; output CNT_W count; load over enable); the scheduler drives load in LOAD and enable in RUN when count != len_q and i_pause low.

Verification
REQ-030 Single requester: i_req=0001, len 3 -> o_grant=0001 from t+1, o_count 0,1,2,3, o_done[0] pulse at t+6.
REQ-031 Contention: i_req=1111 held, all len 1 -> grants in order 0,1,2,3,0, with one o_done per interval.
REQ-032 Boundaries: len 0 -> o_done at t+3 with count 0; len 31 -> count reaches 31, no wrap, o_done at t+34.
REQ-033 Pause: len 4 with i_pause high for 3 RUN cycles -> count holds and o_done is delayed by exactly 3 cycles.
REQ-034 Abort: drop i_req[2] at count 2 of len 10 -> IDLE next cycle, no o_done[2], next grant goes to requester 3 if it is requesting.
REQ-035 Reset mid-RUN: i_rst_n low at count 5 -> all outputs 0 immediately; after release i_req=0110 -> grant 0010.
